// File: rtl/universal_shift_reg.sv
// N-bit hold/load/shift/rotate/clear register with a counted shift/rotate burst sequencer.
// q updates on the sampling edge; no backpressure, and all inputs except sin_r/sin_l are ignored while busy.
module universal_shift_reg #(
    parameter int N     = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [N-1:0]     d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    output logic [N-1:0]     q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     q_q, q_d;
    logic [2:0]       op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;

    function automatic logic [N-1:0] apply_op(
        input logic [2:0]   op,
        input logic [N-1:0] cur,
        input logic [N-1:0] ld,
        input logic         sr,
        input logic         sl
    );
        case (op)
            3'b001:  apply_op = ld;
            3'b010:  apply_op = {sr, cur[N-1:1]};
            3'b011:  apply_op = {cur[N-2:0], sl};
            3'b100:  apply_op = {cur[0], cur[N-1:1]};
            3'b101:  apply_op = {cur[N-2:0], cur[N-1]};
            3'b110:  apply_op = '0;
            default: apply_op = cur;
        endcase
    endfunction

    // Only shift/rotate modes with a nonzero length start a burst.
    assign accept = burst_start && (burst_len != '0) && (mode >= 3'd2) && (mode <= 3'd5);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BURST;
                    op_d    = mode;
                    cnt_d   = burst_len;
                end else begin
                    q_d = apply_op(mode, q_q, d, sin_r, sin_l);
                end
            end
            BURST: begin
                q_d   = apply_op(op_q, q_q, d, sin_r, sin_l);
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            op_q    <= 3'b000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[N-1];
    assign busy   = (state_q == BURST);
    assign done   = done_q;

endmodule
